// File: rtl/zxgs_pkg.sv
// zxgs_pkg: host port addresses, status byte layout and latch reset value shared by the NGS host channel
package zxgs_pkg;
    localparam logic [7:0] ZX_DATA_PORT = 8'hB3;
    localparam logic [7:0] ZX_CMD_PORT  = 8'hBB;
    localparam logic [7:0] ZX_RST_PORT  = 8'h33;
    localparam logic [7:0] LATCH_RESET  = 8'hFF;

    typedef enum logic [1:0] {PORT_NONE, PORT_DATA, PORT_CMD, PORT_RST} port_e;

    function automatic logic [7:0] status_byte(input logic data_bit, input logic command_bit);
        return {data_bit, 6'b111111, command_bit};
    endfunction
endpackage

// File: rtl/zx_strobe_sync.sv
// zx_strobe_sync: synchronises an async host strobe and emits one-cycle start/stop pulses
module zx_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic cpu_clock,
    input  logic rst_n,
    input  logic strobe,
    output logic start,
    output logic stop
);
    // stored inverted so that the reset value 1 means idle
    logic [SYNC_STAGES-1:0] sync_n;
    logic [SYNC_STAGES:0]   fill;
    logic                   prev_n;
    logic                   armed;

    always_ff @(posedge cpu_clock or negedge rst_n) begin
        if (!rst_n) begin
            sync_n <= '1;
            fill   <= '0;
            prev_n <= 1'b1;
            armed  <= 1'b0;
        end else begin
            sync_n <= {sync_n[SYNC_STAGES-2:0], ~strobe};
            fill   <= {fill[SYNC_STAGES-1:0], 1'b1};
            prev_n <= sync_n[SYNC_STAGES-1];
            armed  <= armed | (fill[SYNC_STAGES] & sync_n[SYNC_STAGES-1]);
        end
    end

    // edges count only once a genuinely idle strobe has been seen after reset
    assign start = armed & prev_n & ~sync_n[SYNC_STAGES-1];
    assign stop  = armed & ~prev_n & sync_n[SYNC_STAGES-1];
endmodule

// File: rtl/zxbus_host_port.sv
// zxbus_host_port: Spectrum-side decode of the NGS data/command/reset ports and the shared flags
module zxbus_host_port
    import zxgs_pkg::*;
#(
    parameter logic [7:0] DATA_PORT   = ZX_DATA_PORT,
    parameter logic [7:0] CMD_PORT    = ZX_CMD_PORT,
    parameter logic [7:0] RST_PORT    = ZX_RST_PORT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       cpu_clock,
    input  logic       rst_n,
    input  logic [7:0] zx_a,
    input  logic       zx_iorq_n,
    input  logic       zx_m1_n,
    input  logic       zx_rd_n,
    input  logic       zx_wr_n,
    input  logic [7:0] zx_din,
    output logic [7:0] zx_dout,
    output logic       zx_oe,
    input  logic [7:0] data_port_output,
    input  logic       data_bit_output,
    input  logic       data_bit_wr,
    input  logic       command_bit_output,
    input  logic       command_bit_wr,
    output logic [7:0] data_port_input,
    output logic [7:0] command_port_input,
    output logic       data_bit_input,
    output logic       command_bit_input,
    output logic       gs_rst_req
);
    port_e zx_port, host_port;
    logic  rd_s, wr_s, rd_start, rd_stop, wr_start, wr_stop;
    logic  wr_data, wr_cmd, rd_data_end;

    always_comb zx_port = zx_a == DATA_PORT ? PORT_DATA :
                          zx_a == CMD_PORT  ? PORT_CMD  :
                          zx_a == RST_PORT  ? PORT_RST  : PORT_NONE;

    assign rd_s    = ~zx_iorq_n & zx_m1_n & ~zx_rd_n;
    assign wr_s    = ~zx_iorq_n & zx_m1_n & ~zx_wr_n;
    assign zx_oe   = rd_s & (zx_port == PORT_DATA || zx_port == PORT_CMD);
    assign zx_dout = zx_port == PORT_DATA ? data_port_output :
                     zx_port == PORT_CMD  ? status_byte(data_bit_input, command_bit_input) : 8'hFF;

    zx_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
        .cpu_clock(cpu_clock), .rst_n(rst_n), .strobe(rd_s), .start(rd_start), .stop(rd_stop));
    zx_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
        .cpu_clock(cpu_clock), .rst_n(rst_n), .strobe(wr_s), .start(wr_start), .stop(wr_stop));

    assign wr_data     = wr_start & (zx_port == PORT_DATA);
    assign wr_cmd      = wr_start & (zx_port == PORT_CMD);
    assign rd_data_end = rd_stop & (host_port == PORT_DATA);

    always_ff @(posedge cpu_clock or negedge rst_n) begin
        if (!rst_n) begin
            data_port_input    <= LATCH_RESET;
            command_port_input <= LATCH_RESET;
            data_bit_input     <= 1'b0;
            command_bit_input  <= 1'b0;
            gs_rst_req         <= 1'b0;
            host_port          <= PORT_NONE;
        end else begin
            if (wr_data) data_port_input <= zx_din;
            if (wr_cmd) command_port_input <= zx_din;
            // host events take priority over the NGS-side flag strobes
            data_bit_input    <= wr_data ? 1'b1 : rd_data_end ? 1'b0 :
                                 data_bit_wr ? data_bit_output : data_bit_input;
            command_bit_input <= wr_cmd ? 1'b1 : command_bit_wr ? command_bit_output : command_bit_input;
            gs_rst_req        <= wr_start & (zx_port == PORT_RST) & zx_din[7];
            // the read address is held from read start so the end event acts on the port actually read
            host_port         <= rd_start ? zx_port : (rd_stop | wr_stop) ? PORT_NONE : host_port;
        end
    end
endmodule

// File: tb/tb_zxbus_host_port.sv
// tb_zxbus_host_port: randomized and directed checks of the host port against a flag/latch model
module tb_zxbus_host_port;
    localparam int SS = 2;

    logic       cpu_clock = 0, rst_n = 0;
    logic [7:0] zx_a = 0, zx_din = 0, zx_dout, data_port_output = 0;
    logic       zx_iorq_n = 1, zx_m1_n = 1, zx_rd_n = 1, zx_wr_n = 1, zx_oe;
    logic       data_bit_output = 0, data_bit_wr = 0, command_bit_output = 0, command_bit_wr = 0;
    logic [7:0] data_port_input, command_port_input;
    logic       data_bit_input, command_bit_input, gs_rst_req;

    int checks = 0, errors = 0, pulse_cnt = 0;
    logic [7:0] m_dp, m_cp;
    logic       m_db, m_cb;

    zxbus_host_port #(.SYNC_STAGES(SS)) dut (
        .cpu_clock(cpu_clock), .rst_n(rst_n), .zx_a(zx_a), .zx_iorq_n(zx_iorq_n), .zx_m1_n(zx_m1_n),
        .zx_rd_n(zx_rd_n), .zx_wr_n(zx_wr_n), .zx_din(zx_din), .zx_dout(zx_dout), .zx_oe(zx_oe),
        .data_port_output(data_port_output), .data_bit_output(data_bit_output), .data_bit_wr(data_bit_wr),
        .command_bit_output(command_bit_output), .command_bit_wr(command_bit_wr),
        .data_port_input(data_port_input), .command_port_input(command_port_input),
        .data_bit_input(data_bit_input), .command_bit_input(command_bit_input), .gs_rst_req(gs_rst_req));

    always #5 cpu_clock = ~cpu_clock;
    always @(negedge cpu_clock) if (gs_rst_req) pulse_cnt++;

    function automatic logic [7:0] exp_read(input logic [7:0] a);
        return a == 8'hB3 ? data_port_output : a == 8'hBB ? {m_db, 6'b111111, m_cb} : 8'hFF;
    endfunction

    task automatic model_reset();
        m_dp = 8'hFF; m_cp = 8'hFF; m_db = 0; m_cb = 0;
    endtask

    task automatic host_io(input logic wr, input logic m1, input logic [7:0] a, input logic [7:0] d,
                           output logic oe, output logic [7:0] dout, output int pulses);
        int p0;
        p0 = pulse_cnt;
        zx_a = a; zx_din = d;
        #7;
        zx_m1_n = !m1; zx_iorq_n = 0; zx_wr_n = !wr; zx_rd_n = wr;
        #60;
        oe = zx_oe; dout = zx_dout;
        zx_iorq_n = 1; zx_rd_n = 1; zx_wr_n = 1; zx_m1_n = 1;
        #60;
        pulses = pulse_cnt - p0;
        if (!m1 && wr && a == 8'hB3) begin m_dp = d; m_db = 1; end
        if (!m1 && wr && a == 8'hBB) begin m_cp = d; m_cb = 1; end
        if (!m1 && !wr && a == 8'hB3) m_db = 0;
    endtask

    task automatic ngs_flags(input logic dw, input logic dv, input logic cw, input logic cv);
        @(posedge cpu_clock); #1;
        data_bit_wr = dw; data_bit_output = dv; command_bit_wr = cw; command_bit_output = cv;
        @(posedge cpu_clock); #1;
        data_bit_wr = 0; command_bit_wr = 0;
        if (dw) m_db = dv;
        if (cw) m_cb = cv;
    endtask

    task automatic test_reset();
        logic oe; logic [7:0] dout; int p;
        rst_n = 0; #23; rst_n = 1; model_reset();
        repeat (3) @(posedge cpu_clock); #1;
        checks++; if (data_port_input !== 8'hFF) begin errors++; $display("FAIL reset_dp got %h want ff", data_port_input); end
        checks++; if (command_port_input !== 8'hFF) begin errors++; $display("FAIL reset_cp got %h want ff", command_port_input); end
        checks++; if ({data_bit_input, command_bit_input, gs_rst_req} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {data_bit_input, command_bit_input, gs_rst_req}); end
        checks++; if (zx_oe !== 1'b0) begin errors++; $display("FAIL idle_oe got %b want 0", zx_oe); end
        host_io(0, 0, 8'hBB, 8'h00, oe, dout, p);
        checks++; if (oe !== 1'b1 || dout !== 8'h7E) begin errors++; $display("FAIL reset_status got oe=%b %h want oe=1 7e", oe, dout); end
        checks++; if (data_port_input !== 8'hFF) begin errors++; $display("FAIL status_read_dp got %h want ff", data_port_input); end
    endtask

    task automatic test_write_data();
        logic oe; logic [7:0] dout; int p;
        @(posedge cpu_clock); #1;
        zx_a = 8'hB3; zx_din = 8'h5A; zx_iorq_n = 0; zx_wr_n = 0;
        repeat (SS) @(posedge cpu_clock); #1;
        checks++; if (data_port_input !== 8'hFF || data_bit_input !== 1'b0) begin errors++; $display("FAIL write_early got %h/%b want ff/0", data_port_input, data_bit_input); end
        @(posedge cpu_clock); #1;
        checks++; if (data_port_input !== 8'h5A || data_bit_input !== 1'b1) begin errors++; $display("FAIL write_latency got %h/%b want 5a/1", data_port_input, data_bit_input); end
        zx_iorq_n = 1; zx_wr_n = 1; #60;
        m_dp = 8'h5A; m_db = 1;
        host_io(0, 0, 8'hBB, 8'h00, oe, dout, p);
        checks++; if (dout !== 8'hFE) begin errors++; $display("FAIL status_after_write got %h want fe", dout); end
    endtask

    task automatic test_read_data();
        logic oe; logic [7:0] dout; int p;
        data_port_output = 8'hC3;
        ngs_flags(1, 1, 0, 0);
        host_io(0, 0, 8'hB3, 8'h00, oe, dout, p);
        checks++; if (oe !== 1'b1 || dout !== 8'hC3) begin errors++; $display("FAIL data_read got oe=%b %h want oe=1 c3", oe, dout); end
        checks++; if (data_bit_input !== 1'b0) begin errors++; $display("FAIL data_read_clear got %b want 0", data_bit_input); end
    endtask

    task automatic test_command();
        logic oe; logic [7:0] dout; int p;
        host_io(1, 0, 8'hBB, 8'h20, oe, dout, p);
        checks++; if (command_port_input !== 8'h20 || command_bit_input !== 1'b1) begin errors++; $display("FAIL cmd_write got %h/%b want 20/1", command_port_input, command_bit_input); end
        ngs_flags(0, 0, 1, 0);
        #1;
        checks++; if (command_bit_input !== 1'b0) begin errors++; $display("FAIL cmd_clear got %b want 0", command_bit_input); end
    endtask

    task automatic test_collision();
        @(posedge cpu_clock); #1;
        zx_a = 8'hB3; zx_din = 8'h77; zx_iorq_n = 0; zx_wr_n = 0;
        repeat (SS) @(posedge cpu_clock); #1;
        data_bit_wr = 1; data_bit_output = 0; command_bit_wr = 1; command_bit_output = 1;
        @(posedge cpu_clock); #1;
        data_bit_wr = 0; command_bit_wr = 0;
        checks++; if (data_bit_input !== 1'b1 || data_port_input !== 8'h77) begin errors++; $display("FAIL collision got %b/%h want 1/77", data_bit_input, data_port_input); end
        checks++; if (command_bit_input !== 1'b1) begin errors++; $display("FAIL independent_cmd got %b want 1", command_bit_input); end
        zx_iorq_n = 1; zx_wr_n = 1; #60;
        m_dp = 8'h77; m_db = 1; m_cb = 1;
    endtask

    task automatic test_rst_port_and_m1();
        logic oe; logic [7:0] dout; int p;
        host_io(1, 0, 8'h33, 8'h80, oe, dout, p);
        checks++; if (p !== 1) begin errors++; $display("FAIL rst_pulse got %0d cycles want 1", p); end
        host_io(1, 0, 8'h33, 8'h00, oe, dout, p);
        checks++; if (p !== 0) begin errors++; $display("FAIL rst_no_pulse got %0d cycles want 0", p); end
        host_io(0, 1, 8'hB3, 8'h00, oe, dout, p);
        checks++; if (oe !== 1'b0 || data_bit_input !== m_db) begin errors++; $display("FAIL m1_read got oe=%b db=%b want oe=0 db=%b", oe, data_bit_input, m_db); end
        host_io(1, 1, 8'hB3, 8'h12, oe, dout, p);
        checks++; if (data_port_input !== m_dp) begin errors++; $display("FAIL m1_write got %h want %h", data_port_input, m_dp); end
    endtask

    task automatic test_reset_mid();
        logic oe; logic [7:0] dout; int p;
        zx_a = 8'hB3; zx_din = 8'h11; #3; zx_iorq_n = 0; zx_wr_n = 0;
        #8; rst_n = 0; #12; rst_n = 1; model_reset();
        repeat (8) @(posedge cpu_clock); #1;
        checks++; if (data_port_input !== 8'hFF || data_bit_input !== 1'b0) begin errors++; $display("FAIL held_strobe got %h/%b want ff/0", data_port_input, data_bit_input); end
        zx_iorq_n = 1; zx_wr_n = 1; #60;
        checks++; if (data_port_input !== 8'hFF) begin errors++; $display("FAIL held_release got %h want ff", data_port_input); end
        host_io(1, 0, 8'hB3, 8'h11, oe, dout, p);
        checks++; if (data_port_input !== 8'h11 || data_bit_input !== 1'b1) begin errors++; $display("FAIL rearm_write got %h/%b want 11/1", data_port_input, data_bit_input); end
    endtask

    task automatic test_random();
        logic oe; logic [7:0] dout, a, d, ea; int p, op; logic wr, m1, ep;
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 7);
            d = 8'($urandom);
            data_port_output = 8'($urandom);
            if (op == 6) begin
                ngs_flags(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
                #1;
            end else begin
                wr = op inside {0, 1, 4} || (op >= 5 && 1'($urandom));
                m1 = op == 7;
                a = op == 0 || op == 2 ? 8'hB3 : op == 1 || op == 3 ? 8'hBB : op == 4 ? 8'h33 :
                    op == 7 ? (1'($urandom) ? 8'hB3 : 8'hBB) : 8'h40 + 8'($urandom_range(0, 15));
                ea = exp_read(a);
                ep = !m1 && wr && a == 8'h33 && d[7];
                host_io(wr, m1, a, d, oe, dout, p);
                checks++; if (p !== int'(ep)) begin errors++; $display("FAIL rnd_pulse op=%0d got %0d want %0d", op, p, ep); end
                if (!wr) begin
                    checks++;
                    if (oe !== (!m1 && (a == 8'hB3 || a == 8'hBB)) || (oe && dout !== ea)) begin
                        errors++; $display("FAIL rnd_read op=%0d a=%h got oe=%b %h want %h", op, a, oe, dout, ea);
                    end
                end
            end
            checks++;
            if ({data_port_input, command_port_input, data_bit_input, command_bit_input} !== {m_dp, m_cp, m_db, m_cb}) begin
                errors++; $display("FAIL rnd_state op=%0d got %h %h %b %b want %h %h %b %b", op, data_port_input,
                    command_port_input, data_bit_input, command_bit_input, m_dp, m_cp, m_db, m_cb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_data();
        test_read_data();
        test_command();
        test_collision();
        test_rst_port_and_m1();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
